// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel round-robin valid/ready multiplexer with one registered output stage.
//   Ports: clk, rst_n (async active-low); in_valid/in_last/in_ready [N] per-channel handshake;
//   in_data [N*WIDTH] with channel i at [i*WIDTH +: WIDTH]; out_valid/out_ready output handshake;
//   out_data [WIDTH] registered beat; out_sel [SEL_W] channel that supplied out_data.
//   Macro MUX_RR_PACKET_LOCK_EN: hold the grant on one channel until it sends a beat with in_last set.
module mux_rr_n #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);
  logic             load, xfer, grant_valid, rr_valid, adv;
  logic [SEL_W-1:0] grant, rr_grant, ptr, next_ptr;
  always_comb begin
    rr_valid = 1'b0;
    rr_grant = '0;
    // Descending scan so the last hit is the closest set bit at or after ptr.
    for (int j = N - 1; j >= 0; j--)
      if (in_valid[(int'(ptr) + j) % N]) begin
        rr_valid = 1'b1;
        rr_grant = SEL_W'((int'(ptr) + j) % N);
      end
  end
`ifdef MUX_RR_PACKET_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_sel;
  assign grant_valid = locked ? in_valid[lock_sel] : rr_valid;
  assign grant       = locked ? lock_sel : rr_grant;
  // The pointer only moves when a packet ends, so it stays put across a locked packet.
  assign adv         = in_last[grant];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      locked   <= 1'b0;
      lock_sel <= '0;
    end else if (xfer) begin
      locked   <= ~in_last[grant];
      lock_sel <= grant;
    end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign grant_valid = rr_valid;
  assign grant       = rr_grant;
  assign adv         = 1'b1;
`endif
  assign load     = ~out_valid | out_ready;
  // Gating with rst_n keeps in_ready low while reset forces the output stage empty.
  assign xfer     = rst_n & load & grant_valid;
  assign in_ready = xfer ? N'(1) << grant : '0;
  assign next_ptr = (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (load) out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_sel  <= grant;
        if (adv) ptr <= next_ptr;
      end
    end
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed bench for mux_rr_n with a per-cycle behavioural reference.
module tb_mux_rr_n;
  localparam int W = 32;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  mux_rr_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cnt[N];
  int ch1_sent = 0;
  logic [N-1:0] acc = '0;
  int seq_s[$];
  logic [W-1:0] seq_d[$];
  int exp_s[$];
  logic [W-1:0] exp_d[$];
  // Reference state: what the output register holds and where the search starts.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
`ifdef MUX_RR_PACKET_LOCK_EN
  logic         m_lock;
  int           m_lk;
`endif
  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int m_grant();
`ifdef MUX_RR_PACKET_LOCK_EN
    if (m_lock) return in_valid[m_lk] ? m_lk : -1;
`endif
    for (int j = 0; j < N; j++)
      if (in_valid[(m_ptr + j) % N]) return (m_ptr + j) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] m_ready();
    if (!rst_n || !(!m_valid || out_ready) || m_grant() < 0) return '0;
    return N'(1) << m_grant();
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_ptr   <= 0;
`ifdef MUX_RR_PACKET_LOCK_EN
      m_lock  <= 1'b0;
      m_lk    <= 0;
`endif
    end else if (m_ready() != '0) begin
      m_valid <= 1'b1;
      m_data  <= in_data[m_grant()*W +: W];
      m_sel   <= m_grant();
`ifdef MUX_RR_PACKET_LOCK_EN
      m_lock  <= !in_last[m_grant()];
      m_lk    <= m_grant();
      if (in_last[m_grant()]) m_ptr <= (m_grant() + 1) % N;
`else
      m_ptr   <= (m_grant() + 1) % N;
`endif
    end else if (out_ready) m_valid <= 1'b0;
  always @(negedge clk) begin
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_sel", W'(out_sel), W'(m_sel));
    chk("in_ready", W'(in_ready), W'(m_ready()));
    acc <= in_valid & in_ready;
    if (rst_n && out_valid && out_ready) begin
      seq_s.push_back(int'(out_sel));
      seq_d.push_back(out_data);
    end
  end
  task automatic drive_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(32'hA000_0000 + (i << 16) + cnt[i]);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        cnt[i]++;
        if (i == 1) ch1_sent++;
      end
    drive_data();
  endtask
  task automatic check_seq(string name, bit with_data);
    chk({name, "_len"}, W'(seq_s.size()), W'(exp_s.size()));
    for (int k = 0; k < exp_s.size(); k++) begin
      chk({name, "_sel"}, (k < seq_s.size()) ? W'(seq_s[k]) : '1, W'(exp_s[k]));
      if (with_data) chk({name, "_data"}, (k < seq_d.size()) ? seq_d[k] : '1, exp_d[k]);
    end
    seq_s.delete();
    seq_d.delete();
  endtask
  initial begin
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive_data();
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ready", W'(in_ready), '0);
    #2 rst_n = 1'b1;
    seq_s.delete();
    seq_d.delete();
    repeat (6) step();
    in_valid = '0;
    step();
    exp_s = '{0, 1, 2, 3, 0, 1};
    exp_d = '{32'hA000_0000, 32'hA001_0000, 32'hA002_0000, 32'hA003_0000, 32'hA000_0001, 32'hA001_0001};
    check_seq("all_valid", 1'b1);
    in_valid = 4'b0010;
    step();
    in_valid = '0;
    step();
    seq_s.delete();
    seq_d.delete();
    in_valid = 4'b1010;
    repeat (3) step();
    in_valid = '0;
    step();
    exp_s = '{3, 1, 3};
    exp_d = '{32'hA003_0001, 32'hA001_0003, 32'hA003_0002};
    check_seq("sparse", 1'b1);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", W'(out_valid), W'(1));
      chk("stall_data", out_data, 32'hA000_0002);
      chk("stall_ready", W'(in_ready), '0);
      if (c < 3) step();
    end
    out_ready = 1'b1;
    #1 chk("resume_ready", W'(in_ready), W'(4'b0010));
    step();
    chk("resume_sel", W'(out_sel), W'(1));
    chk("resume_data", out_data, 32'hA001_0004);
    step();
    chk("pre_rst_sel", W'(out_sel), W'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", W'(out_valid), '0);
    chk("async_rst_data", out_data, '0);
    in_valid = 4'b0001;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_sel", W'(out_sel), W'(0));
    chk("post_rst_valid", W'(out_valid), W'(1));
    chk("post_rst_data", out_data, 32'hA000_0003);
    in_valid = '0;
    step();
    seq_s.delete();
    seq_d.delete();
    ch1_sent = 0;
    for (int b = 0; b < 5; b++) begin
      in_valid = {2'b11, ch1_sent < 3, 1'b0};
      in_last  = {2'b11, ch1_sent == 2, 1'b1};
      step();
    end
    in_valid = '0;
    step();
`ifdef MUX_RR_PACKET_LOCK_EN
    exp_s = '{1, 1, 1, 2, 3};
`else
    exp_s = '{1, 2, 3, 1, 2};
`endif
    check_seq("packet", 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
